// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: cycle and per-channel event counters with a cycle limit,
// plus a snapshot that is streamed out one record per beat over a valid/ready port.
module pipe_perf_monitor #(
  parameter int unsigned NUM_EVT    = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned SAT        = 0,
  parameter int unsigned MAX_CYCLES = 30,
  parameter int unsigned IDX_W      = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clr_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [31:0]        pc_i,
  input  logic               dump_req_i,
  input  logic               dump_ready_i,
  output logic               dump_valid_o,
  output logic [IDX_W-1:0]   dump_idx_o,
  output logic [CNT_W-1:0]   dump_data_o,
  output logic               dump_last_o,
  output logic               busy_o,
  output logic [NUM_EVT:0]   ovf_o,
  output logic               done_o
);

  localparam int unsigned NumSlot = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_EVT + 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] evt_q [NUM_EVT];
  logic [CNT_W-1:0] evt_d [NUM_EVT];
  logic [NUM_EVT:0] ovf_q, ovf_d;
  // Sized to the full index space so any idx value selects a defined slot.
  logic [CNT_W-1:0] shadow_q [NumSlot];
  logic [CNT_W-1:0] shadow_d [NumSlot];

  logic [CNT_W:0]   cyc_step;
  logic [CNT_W:0]   evt_step [NUM_EVT];
  logic [CNT_W-1:0] pc_fit;
  logic             done;
  logic             cnt_en;
  logic             sending;

  // Returns {overflow, next value} for one increment.
  function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] v);
    if (v == CntMax) begin
      bump = {1'b1, (SAT != 0) ? CntMax : {CNT_W{1'b0}}};
    end else begin
      bump = {1'b0, v + CNT_W'(1)};
    end
  endfunction

  assign done    = (MAX_CYCLES != 0) && (cyc_q == CNT_W'(MAX_CYCLES));
  assign cnt_en  = start_i & ~done & ~clr_i;
  assign pc_fit  = CNT_W'(pc_i);
  assign sending = (state_q == StSend);

  always_comb begin
    cyc_step = bump(cyc_q);
    for (int k = 0; k < int'(NUM_EVT); k++) begin
      evt_step[k] = bump(evt_q[k]);
    end
  end

  always_comb begin
    cyc_d = cyc_q;
    ovf_d = ovf_q;
    for (int k = 0; k < int'(NUM_EVT); k++) begin
      evt_d[k] = evt_q[k];
    end
    if (clr_i) begin
      cyc_d = '0;
      ovf_d = '0;
      for (int k = 0; k < int'(NUM_EVT); k++) begin
        evt_d[k] = '0;
      end
    end else if (cnt_en) begin
      cyc_d    = cyc_step[CNT_W-1:0];
      ovf_d[0] = ovf_q[0] | cyc_step[CNT_W];
      for (int k = 0; k < int'(NUM_EVT); k++) begin
        if (evt_i[k]) begin
          evt_d[k]   = evt_step[k][CNT_W-1:0];
          ovf_d[k+1] = ovf_q[k+1] | evt_step[k][CNT_W];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    for (int s = 0; s < int'(NumSlot); s++) begin
      shadow_d[s] = shadow_q[s];
    end
    unique case (state_q)
      StIdle: begin
        if (dump_req_i) begin
          // Snapshot takes the pre-edge counter values.
          shadow_d[0] = cyc_q;
          for (int k = 0; k < int'(NUM_EVT); k++) begin
            shadow_d[k+1] = evt_q[k];
          end
          shadow_d[NUM_EVT+1] = pc_fit;
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (dump_ready_i) begin
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cyc_q   <= '0;
      ovf_q   <= '0;
      for (int k = 0; k < int'(NUM_EVT); k++) begin
        evt_q[k] <= '0;
      end
      for (int s = 0; s < int'(NumSlot); s++) begin
        shadow_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k < int'(NUM_EVT); k++) begin
        evt_q[k] <= evt_d[k];
      end
      for (int s = 0; s < int'(NumSlot); s++) begin
        shadow_q[s] <= shadow_d[s];
      end
    end
  end

  assign busy_o       = sending;
  assign dump_valid_o = sending;
  assign dump_idx_o   = idx_q;
  assign dump_data_o  = sending ? shadow_q[idx_q] : '0;
  assign dump_last_o  = sending && (idx_q == LastIdx);
  assign ovf_o        = ovf_q;
  assign done_o       = done;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Bench for pipe_perf_monitor: three instances (32-bit limited, 4-bit wrapping, 4-bit saturating)
// checked every cycle against an arithmetic model, plus directed literal scenarios.
module tb_pipe_perf_monitor;

  logic        clk = 1'b0;
  logic        rst, start, clr, req, ready;
  logic [3:0]  evt;
  logic [31:0] pc;

  logic [2:0]  o_valid, o_last, o_busy, o_done;
  logic [2:0]  o_idx  [3];
  logic [4:0]  o_ovf  [3];
  logic [31:0] d0;
  logic [3:0]  d1, d2;
  logic [63:0] o_data [3];

  assign o_data[0] = 64'(d0);
  assign o_data[1] = 64'(d1);
  assign o_data[2] = 64'(d2);

  always #5 clk = ~clk;

  pipe_perf_monitor #(.NUM_EVT(4), .CNT_W(32), .SAT(0), .MAX_CYCLES(30), .IDX_W(3)) u_main (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clr_i(clr), .evt_i(evt), .pc_i(pc),
    .dump_req_i(req), .dump_ready_i(ready), .dump_valid_o(o_valid[0]), .dump_idx_o(o_idx[0]),
    .dump_data_o(d0), .dump_last_o(o_last[0]), .busy_o(o_busy[0]), .ovf_o(o_ovf[0]),
    .done_o(o_done[0])
  );

  pipe_perf_monitor #(.NUM_EVT(4), .CNT_W(4), .SAT(0), .MAX_CYCLES(0), .IDX_W(3)) u_wrap (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clr_i(clr), .evt_i(evt), .pc_i(pc),
    .dump_req_i(req), .dump_ready_i(ready), .dump_valid_o(o_valid[1]), .dump_idx_o(o_idx[1]),
    .dump_data_o(d1), .dump_last_o(o_last[1]), .busy_o(o_busy[1]), .ovf_o(o_ovf[1]),
    .done_o(o_done[1])
  );

  pipe_perf_monitor #(.NUM_EVT(4), .CNT_W(4), .SAT(1), .MAX_CYCLES(0), .IDX_W(3)) u_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clr_i(clr), .evt_i(evt), .pc_i(pc),
    .dump_req_i(req), .dump_ready_i(ready), .dump_valid_o(o_valid[2]), .dump_idx_o(o_idx[2]),
    .dump_data_o(d2), .dump_last_o(o_last[2]), .busy_o(o_busy[2]), .ovf_o(o_ovf[2]),
    .done_o(o_done[2])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Counts are kept as unbounded integers; width effects are applied only when observed.
  longint n_cyc [3];
  longint n_evt [3][4];
  longint beat  [3][6];
  int     ptr   [3];
  bit     model_ok = 1'b0;

  function automatic int width_of(input int i);
    return (i == 0) ? 32 : 4;
  endfunction

  function automatic longint lim_of(input int i);
    return longint'(1) << width_of(i);
  endfunction

  function automatic longint vis(input int i, input longint n);
    if (i == 2) return (n >= lim_of(i) - 1) ? lim_of(i) - 1 : n;
    return n % lim_of(i);
  endfunction

  function automatic bit exp_done(input int i);
    return (i == 0) && (vis(i, n_cyc[i]) == 30);
  endfunction

  function automatic logic [4:0] exp_ovf(input int i);
    logic [4:0] v;
    v[0] = n_cyc[i] >= lim_of(i);
    for (int k = 0; k < 4; k++) v[k+1] = n_evt[i][k] >= lim_of(i);
    return v;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        n_cyc[i] = 0;
        for (int k = 0; k < 4; k++) n_evt[i][k] = 0;
        ptr[i] = -1;
      end else begin
        bit dn;
        dn = exp_done(i);
        if (ptr[i] < 0) begin
          if (req) begin
            beat[i][0] = vis(i, n_cyc[i]);
            for (int k = 0; k < 4; k++) beat[i][k+1] = vis(i, n_evt[i][k]);
            beat[i][5] = longint'(pc) & (lim_of(i) - 1);
            ptr[i] = 0;
          end
        end else if (ready) begin
          ptr[i] = (ptr[i] == 5) ? -1 : ptr[i] + 1;
        end
        if (clr) begin
          n_cyc[i] = 0;
          for (int k = 0; k < 4; k++) n_evt[i][k] = 0;
        end else if (start && !dn) begin
          n_cyc[i]++;
          for (int k = 0; k < 4; k++) n_evt[i][k] += longint'(evt[k]);
        end
      end
    end
    if (rst) model_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("i%0d_valid", i), o_valid[i], ptr[i] >= 0);
        chk($sformatf("i%0d_busy", i), o_busy[i], ptr[i] >= 0);
        chk($sformatf("i%0d_done", i), o_done[i], exp_done(i));
        chk($sformatf("i%0d_ovf", i), o_ovf[i], exp_ovf(i));
        if (ptr[i] >= 0) begin
          chk($sformatf("i%0d_idx", i), o_idx[i], ptr[i]);
          chk($sformatf("i%0d_data", i), o_data[i], beat[i][ptr[i]]);
          chk($sformatf("i%0d_last", i), o_last[i], ptr[i] == 5);
        end
      end
    end
  end

  // Record accepted beats for the literal checks.
  logic [63:0] cap [3][8];
  int n_hs, n_last, n_busy, last_at;

  always @(negedge clk) begin
    if (o_busy[0]) n_busy++;
    for (int i = 0; i < 3; i++) begin
      if (o_valid[i] && ready) cap[i][o_idx[i]] = o_data[i];
    end
    if (o_valid[0] && ready) begin
      n_hs++;
      if (o_last[0]) begin
        n_last++;
        last_at = int'(o_idx[0]);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_cap();
    for (int i = 0; i < 3; i++) for (int j = 0; j < 8; j++) cap[i][j] = '1;
    n_hs = 0; n_last = 0; n_busy = 0; last_at = -1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (o_busy[0] && n < 40) begin
      tick();
      n++;
    end
    chk(name, o_busy[0], 1'b0);
  endtask

  task automatic dump_wait(input string name);
    clear_cap();
    ready = 1'b1;
    req = 1'b1;
    tick();
    req = 1'b0;
    wait_idle(name);
  endtask

  task automatic wait_idx(input int want, input string name);
    int n;
    n = 0;
    while (!(o_valid[0] && int'(o_idx[0]) == want) && n < 20) begin
      tick();
      n++;
    end
    chk(name, o_idx[0], want);
  endtask

  task automatic run10();
    start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      evt = (c % 2 == 0 && c < 8) ? 4'b0100 : 4'b0000;
      tick();
    end
    start = 1'b0;
    evt = '0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clr = 1'b0; evt = '0; pc = '0; req = 1'b0; ready = 1'b1;
    clear_cap();
    tick();
    rst = 1'b0;

    // Cycle limit, freeze, clear and resume.
    start = 1'b1;
    repeat (30) tick();
    chk("t1_done", o_done[0], 1'b1);
    repeat (5) tick();
    dump_wait("t1_dump_end");
    chk("t1_cyc_frozen", cap[0][0], 30);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t1_done_clr", o_done[0], 1'b0);
    tick();
    tick();
    dump_wait("t1_dump2_end");
    chk("t1_cyc_resume", cap[0][0], 2);

    // clr beats coincident events.
    start = 1'b0;
    do_reset();
    start = 1'b1;
    evt = 4'b0011;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    evt = 4'b0001;
    tick();
    tick();
    evt = '0;
    start = 1'b0;
    dump_wait("t2_dump_end");
    chk("t2_cyc", cap[0][0], 2);
    chk("t2_evt0", cap[0][1], 2);
    chk("t2_evt1", cap[0][2], 0);
    chk("t2_ovf", o_ovf[0], 0);

    // Plain dump with ready held high.
    do_reset();
    run10();
    pc = 32'h1C;
    dump_wait("t3_dump_end");
    chk("t3_b0", cap[0][0], 10);
    chk("t3_b1", cap[0][1], 0);
    chk("t3_b2", cap[0][2], 0);
    chk("t3_b3", cap[0][3], 4);
    chk("t3_b4", cap[0][4], 0);
    chk("t3_b5", cap[0][5], 28);
    chk("t3_nlast", n_last, 1);
    chk("t3_last_at", last_at, 5);
    chk("t3_nbusy", n_busy, 6);
    chk("t3_nbeats", n_hs, 6);

    // Backpressure on idx 2 plus an ignored mid-dump request.
    do_reset();
    run10();
    clear_cap();
    ready = 1'b1;
    req = 1'b1;
    tick();
    req = 1'b0;
    wait_idx(2, "t4_reach2");
    ready = 1'b0;
    req = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      req = 1'b0;
      chk("t4_idx_hold", o_idx[0], 2);
      chk("t4_valid_hold", o_valid[0], 1'b1);
    end
    ready = 1'b1;
    wait_idle("t4_dump_end");
    chk("t4_nbeats", n_hs, 6);
    chk("t4_b3", cap[0][3], 4);
    chk("t4_b5", cap[0][5], 28);
    repeat (4) tick();
    chk("t4_no_second", o_busy[0], 1'b0);

    // 4-bit counters: wrap versus saturate.
    do_reset();
    pc = '0;
    start = 1'b1;
    evt = 4'b0001;
    repeat (17) tick();
    evt = '0;
    start = 1'b0;
    dump_wait("t5_dump_end");
    chk("t5_wrap_cnt", cap[1][1], 1);
    chk("t5_sat_cnt", cap[2][1], 15);
    chk("t5_wrap_ovf", o_ovf[1][1], 1'b1);
    chk("t5_sat_ovf", o_ovf[2][1], 1'b1);
    chk("t5_main_cnt", cap[0][1], 17);

    // Reset aborts a dump in flight.
    do_reset();
    start = 1'b1;
    evt = 4'b1111;
    repeat (5) tick();
    start = 1'b0;
    evt = '0;
    clear_cap();
    req = 1'b1;
    tick();
    req = 1'b0;
    wait_idx(3, "t6_reach3");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_valid", o_valid[0], 1'b0);
    chk("t6_busy", o_busy[0], 1'b0);
    chk("t6_ovf", o_ovf[0], 0);
    dump_wait("t6_dump_end");
    for (int j = 0; j < 5; j++) chk($sformatf("t6_zero%0d", j), cap[0][j], 0);

    // Randomized traffic; the model comparisons run every cycle.
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 499) == 0);
      start = ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 31) == 0);
      evt   = 4'($urandom);
      req   = ($urandom_range(0, 7) == 0);
      ready = 1'($urandom_range(0, 1));
      pc    = $urandom;
      tick();
    end
    rst = 1'b0; clr = 1'b0; req = 1'b0; start = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_perf_monitor.md
Name: pipe_perf_monitor

Overview:
Parametrised pipeline performance monitor for the CPU. It takes over in hardware the cycle, stall and flush bookkeeping currently done by the bench. It counts cycles and NUM_EVT per-channel event pulses (stall, flush, retire, ...) while start_i is high, and stops at a configurable cycle limit. On request it snapshots all counters plus the current PC and streams them out over a valid/ready dump port.

Parameters:
NUM_EVT, 4, number of event channels
CNT_W, 32, width of every counter and of dump_data_o
SAT, 0, 0 = counters wrap, 1 = counters saturate at all-ones
MAX_CYCLES, 30, cycle limit after which counting freezes; 0 = unlimited
IDX_W, 3, dump index width; must satisfy 2^IDX_W >= NUM_EVT+2

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
start_i  in  1  counting enable
clr_i  in  1  synchronous clear of live counters, overflow flags and done
evt_i  in  NUM_EVT  per-channel event strobes, one count per high cycle
pc_i  in  32  current PC, captured at snapshot
dump_req_i  in  1  snapshot-and-dump request
dump_ready_i  in  1  consumer ready
dump_valid_o  out  1  dump beat valid
dump_idx_o  out  IDX_W  record index of current beat
dump_data_o  out  CNT_W  record value
dump_last_o  out  1  final beat of dump
busy_o  out  1  dump in progress
ovf_o  out  NUM_EVT+1  sticky overflow flags; bit0 = cycle counter, bit k = evt_i[k-1]
done_o  out  1  cycle limit reached

Behaviour:
- Reset: every counter, shadow register, ovf_o, dump_idx_o, dump_data_o = 0; dump_valid_o, dump_last_o, busy_o, done_o = 0; FSM = IDLE. Reset overrides all other inputs.
- Counting enable: cnt_en = start_i & ~done_o & ~clr_i.
- When cnt_en is high, the cycle counter increments on every edge. Event counter k increments when evt_i[k] is high.
- Latency: an event in cycle n is visible in the counter in cycle n+1.
- clr_i beats simultaneous events: all counters, ovf_o and done_o go to 0. An in-progress dump and its shadow registers are unaffected.
- Width rules:
  - SAT=0: an increment at all-ones wraps to 0 and sets the matching ovf_o bit.
  - SAT=1: an increment attempted at all-ones holds the value and sets the ovf_o bit.
  - ovf_o bits are sticky until clr_i or rst_i.
- done_o is a combinational compare of the registered cycle counter: done_o = (MAX_CYCLES != 0) & (cycle_cnt == MAX_CYCLES). While done_o is high, no counter changes. Dumps remain allowed.
- FSM IDLE:
  - busy_o=0, dump_valid_o=0.
  - dump_req_i=1 at an edge loads the shadows: shadow[0] = cycle counter, shadow[1..NUM_EVT] = event counters, shadow[NUM_EVT+1] = pc_i zero-extended or truncated to CNT_W.
  - Shadows take the registered values visible in the request cycle, excluding that edge's increment.
  - That edge also sets idx = 0 and goes to SEND.
- FSM SEND:
  - busy_o=1, dump_valid_o=1, dump_idx_o = idx, dump_data_o = shadow[idx], dump_last_o = (idx == NUM_EVT+1).
  - On valid & ready: idx increments. If the beat was last, go to IDLE; dump_valid_o is 0 in the following cycle.
  - While valid & ~ready, idx and data hold stable.
  - dump_req_i in SEND is ignored, not queued.
  - Live counters keep counting during SEND.
- Back-to-back dumps: a new request is accepted earliest in the first IDLE cycle after the last beat.
- rst_i mid-dump aborts it: next cycle dump_valid_o=0, FSM=IDLE.

Test Plan:
1. Reset, start_i=1, no events, MAX_CYCLES=30 → after 30 edges cycle counter=30, done_o=1; 5 more cycles it stays 30; clr_i pulse → 0, counting resumes.
2. evt_i[0] high 3 cycles, evt_i[1] high 1 cycle coincident with clr_i → evt0 count=2 (third pulse lost to clear... first pulse cleared if coincident; bench checks exact value per chosen timing), evt1 count=0, ovf_o=0.
3. Run 10 cycles, evt_i[2] pulsed 4 times, dump_req_i with pc_i=0x1C, dump_ready_i=1 → 6 consecutive beats idx 0..5, data 10,0,0,4,0,28, dump_last_o only on idx 5, busy_o high 6 cycles.
4. Same dump with dump_ready_i low 3 cycles on idx 2, plus a dump_req_i pulse mid-dump → idx/data held stable, 6 beats total, no second dump.
5. CNT_W=4, MAX_CYCLES=0, 17 evt_i[0] pulses → SAT=0: count=1, ovf_o[1]=1; SAT=1: count=15, ovf_o[1]=1.
6. rst_i asserted while dump at idx 3 → next cycle dump_valid_o=0, busy_o=0, all counters and ovf_o = 0; a fresh dump_req_i then returns all-zero counters.
